aes_inv_key_sched: RTL

//  Inverse AES-128 key schedule. Accepts the final (round-10) round key and walks the

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_inv_key_sched_if.sv | 26 ++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_inv_key_sched.sv | 106 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the inverse AES-128 key schedule.
//   KW, NR      : key width and round count (AES-128 only)
//   RCON        : round constants, indexed by round number 1..10 (other slots zero)
//   state_e     : schedule controller states
//   xtime       : GF(2^8) multiply by 2
//   gf_mul      : GF(2^8) multiply by a small constant (up to 15)
//   inv_mix_col : InvMixColumns on one 32-bit column, byte0 in [31:24]
package aes_pkg;

  localparam int KW = 128;
  localparam int NR = 10;

  // Padded to 16 entries so a 4-bit round index never selects outside the table.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle for the inverse key schedule.
//   master : key source / round-key consumer (drives in_valid, key_in, out_ready)
//   slave  : the schedule block (drives in_ready, out_valid, rk_out, rk_idx, rk_last)
// Keys and round keys carry word0 in [127:96].
interface aes_inv_key_sched_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [aes_pkg::KW-1:0]   key_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [aes_pkg::KW-1:0]   rk_out;
  logic [3:0]               rk_idx;
  logic                     rk_last;

  modport master (
    output in_valid, key_in, out_ready,
    input  in_ready, out_valid, rk_out, rk_idx, rk_last
  );

  modport slave (
    input  in_valid, key_in, out_ready,
    output in_ready, out_valid, rk_out, rk_idx, rk_last
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   a_i : input byte
//   s_o : substituted byte
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Entry 0x00 sits in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a lives at bit offset (255 - a) * 8 = {~a, 3'b000}.
  logic [10:0] base;
  assign base = {~a_i, 3'b000};
  assign s_o  = SBOX[base +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule. Takes the round-10 key and emits round keys
// 10 down to 0, one per accepted output beat, walking the expansion backwards.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : handshake bundle (slave side) carrying key_in, rk_out, rk_idx, rk_last
// Build option: AES_EQ_INV_KEY_EN applies InvMixColumns to rk_out for rounds 1..9
// (equivalent inverse cipher). The internal register always keeps the raw key.
//
// state | meaning
// IDLE  | waiting for a key, in_ready high
// RUN   | presenting round key rk_idx, out_valid high
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_inv_key_sched_if.slave  bus
);

  state_e          state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [3:0]      idx_q, idx_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w0n, w1n, w2n, w3n;
  logic [31:0] rot, sub;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Undo one forward expansion step: previous words come from xor of neighbours,
  // and word0 needs SubWord(RotWord) of the recovered word3.
  assign w3n = w3 ^ w2;
  assign w2n = w2 ^ w1;
  assign w1n = w1 ^ w0;
  assign rot = {w3n[23:0], w3n[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot[8*i +: 8]),
      .s_o (sub[8*i +: 8])
    );
  end

  assign w0n = w0 ^ sub ^ {RCON[idx_q], 24'h0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          key_d   = bus.key_in;
          idx_d   = 4'(NR);
        end
      end
      RUN: begin
        if (idx_q > 4'(NR)) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d = {w0n, w1n, w2n, w3n};
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == RUN);
  assign bus.rk_idx    = idx_q;
  assign bus.rk_last   = (state_q == RUN) && (idx_q == 4'd0);

`ifdef AES_EQ_INV_KEY_EN
  // Rounds 10 and 0 are add-round-key only, so they stay raw.
  always_comb begin
    bus.rk_out = key_q;
    if (idx_q != 4'd0 && idx_q < 4'(NR)) begin
      bus.rk_out = {inv_mix_col(w0), inv_mix_col(w1), inv_mix_col(w2), inv_mix_col(w3)};
    end
  end
`else
  assign bus.rk_out = key_q;
`endif

endmodule
